// File: rtl/prefetch_cache_nway.sv
// N-way set-associative cache with tree-PLRU replacement, dirty writeback and a
// prefetch install port that tracks how many prefetched lines are later demand-hit.
module prefetch_cache_nway #(
    parameter int unsigned S_OFFSET = 5,
    parameter int unsigned S_INDEX  = 3,
    parameter int unsigned NUM_WAYS = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [31:0]  mem_address,
    input  logic         mem_read,
    input  logic         mem_write,
    input  logic [255:0] mem_wdata256,
    input  logic [31:0]  mem_byte_enable256,
    output logic [255:0] mem_rdata256,
    output logic         mem_resp,
    output logic [31:0]  pmem_address,
    output logic         pmem_read,
    output logic         pmem_write,
    output logic [255:0] pmem_wdata,
    input  logic [255:0] pmem_rdata,
    input  logic         pmem_resp,
    input  logic         pf_valid,
    input  logic [31:0]  pf_address,
    input  logic [255:0] pf_rdata,
    output logic         pf_ack,
    output logic [31:0]  pf_useful_count
);
    localparam int unsigned S_TAG  = 32 - S_OFFSET - S_INDEX;
    localparam int unsigned SETS   = 2 ** S_INDEX;
    localparam int unsigned WAY_W  = $clog2(NUM_WAYS);
    localparam int unsigned PLRU_W = NUM_WAYS - 1;
    localparam int unsigned LINE_W = 256;
    localparam int unsigned BE_W   = 32;

    typedef enum logic [1:0] {IDLE, WB, FILL, PF_WB} state_t;

    state_t                r_state, w_next;
    logic [LINE_W-1:0]     r_data  [SETS][NUM_WAYS];
    logic [S_TAG-1:0]      r_tag   [SETS][NUM_WAYS];
    logic [NUM_WAYS-1:0]   r_valid [SETS];
    logic [NUM_WAYS-1:0]   r_dirty [SETS];
    logic [NUM_WAYS-1:0]   r_pf    [SETS];
    logic [PLRU_W-1:0]     r_plru  [SETS];
    logic [WAY_W-1:0]      r_vway;
    logic [31:0]           r_useful;

    logic                  w_demand, w_use_pf, w_hit, w_found, w_vdirty;
    logic [31:0]           w_addr;
    logic [S_TAG-1:0]      w_tag;
    logic [S_INDEX-1:0]    w_idx;
    logic [WAY_W-1:0]      w_hit_way, w_victim;
    logic                  w_dem_hit, w_pf_inst, w_fill_done, w_pfwb_done;
    logic                  w_unused_lsbs;

    // Walk the tree following the node bits to the least-recently-used way.
    function automatic logic [WAY_W-1:0] plru_victim(input logic [PLRU_W-1:0] t);
        logic [WAY_W-1:0] w;
        int unsigned      node;
        w    = '0;
        node = 0;
        for (int l = 0; l < int'(WAY_W); l++) begin
            w[WAY_W-1-l] = t[node];
            node = 2 * node + 1 + 32'(t[node]);
        end
        return w;
    endfunction

    // Point every node on the accessed way's path away from that way.
    function automatic logic [PLRU_W-1:0] plru_touch(input logic [PLRU_W-1:0] t,
                                                      input logic [WAY_W-1:0]  w);
        logic [PLRU_W-1:0] r;
        int unsigned       node;
        r    = t;
        node = 0;
        for (int l = 0; l < int'(WAY_W); l++) begin
            r[node] = ~w[WAY_W-1-l];
            node = 2 * node + 1 + 32'(w[WAY_W-1-l]);
        end
        return r;
    endfunction

    assign w_demand      = mem_read | mem_write;
    assign w_use_pf      = (r_state == PF_WB) || ((r_state == IDLE) && !w_demand);
    assign w_addr        = w_use_pf ? pf_address : mem_address;
    assign w_tag         = w_addr[31 -: S_TAG];
    assign w_idx         = w_addr[S_OFFSET +: S_INDEX];
    assign w_unused_lsbs = ^w_addr[S_OFFSET-1:0];

    always_comb begin
        w_hit     = 1'b0;
        w_hit_way = '0;
        w_found   = 1'b0;
        w_victim  = plru_victim(r_plru[w_idx]);
        for (int w = 0; w < int'(NUM_WAYS); w++) begin
            if (r_valid[w_idx][w] && (r_tag[w_idx][w] == w_tag)) begin
                w_hit     = 1'b1;
                w_hit_way = WAY_W'(w);
            end
            if (!r_valid[w_idx][w] && !w_found) begin
                w_found  = 1'b1;
                w_victim = WAY_W'(w);
            end
        end
    end

    assign w_vdirty    = r_valid[w_idx][w_victim] & r_dirty[w_idx][w_victim];
    assign w_dem_hit   = (r_state == IDLE) && w_demand && w_hit;
    assign w_pf_inst   = (r_state == IDLE) && !w_demand && pf_valid && !w_hit && !w_vdirty;
    assign w_fill_done = (r_state == FILL) && pmem_resp;
    assign w_pfwb_done = (r_state == PF_WB) && pmem_resp;

    // Next state and outputs; responses are gated off while reset is held.
    always_comb begin
        w_next       = r_state;
        mem_resp     = 1'b0;
        mem_rdata256 = '0;
        pf_ack       = 1'b0;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = '0;
        pmem_wdata   = '0;
        case (r_state)
            IDLE: begin
                if (w_demand) begin
                    if (w_hit) begin
                        mem_resp     = 1'b1;
                        mem_rdata256 = r_data[w_idx][w_hit_way];
                    end else begin
                        w_next = w_vdirty ? WB : FILL;
                    end
                end else if (pf_valid) begin
                    if (w_hit || !w_vdirty) pf_ack = 1'b1;
                    else                    w_next = PF_WB;
                end
            end
            WB, PF_WB: begin
                pmem_write   = 1'b1;
                pmem_address = {r_tag[w_idx][r_vway], w_idx, {S_OFFSET{1'b0}}};
                pmem_wdata   = r_data[w_idx][r_vway];
                if (pmem_resp) begin
                    w_next = (r_state == WB) ? FILL : IDLE;
                    pf_ack = (r_state == PF_WB);
                end
            end
            FILL: begin
                pmem_read    = 1'b1;
                pmem_address = {w_tag, w_idx, {S_OFFSET{1'b0}}};
                if (pmem_resp) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
        if (!rst) begin
            mem_resp     = 1'b0;
            mem_rdata256 = '0;
            pf_ack       = 1'b0;
        end
    end

    assign pf_useful_count = r_useful;

    // State, line status bits, replacement state and the useful-prefetch counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= IDLE;
            r_vway   <= '0;
            r_useful <= '0;
            for (int s = 0; s < int'(SETS); s++) begin
                r_valid[s] <= '0;
                r_dirty[s] <= '0;
                r_pf[s]    <= '0;
                r_plru[s]  <= '0;
            end
        end else begin
            r_state <= w_next;
            if (w_dem_hit) begin
                r_plru[w_idx] <= plru_touch(r_plru[w_idx], w_hit_way);
                if (mem_write) r_dirty[w_idx][w_hit_way] <= 1'b1;
                if (r_pf[w_idx][w_hit_way]) begin
                    r_pf[w_idx][w_hit_way] <= 1'b0;
                    r_useful               <= r_useful + 32'd1;
                end
            end
            if ((r_state == IDLE) && (w_next != IDLE)) r_vway <= w_victim;
            if (w_pf_inst) begin
                r_valid[w_idx][w_victim] <= 1'b1;
                r_dirty[w_idx][w_victim] <= 1'b0;
                r_pf[w_idx][w_victim]    <= 1'b1;
            end
            if (w_fill_done || w_pfwb_done) begin
                r_valid[w_idx][r_vway] <= 1'b1;
                r_dirty[w_idx][r_vway] <= 1'b0;
                r_pf[w_idx][r_vway]    <= w_pfwb_done;
            end
        end
    end

    // Tag and data arrays carry no reset; valid bits qualify their contents.
    always_ff @(posedge clk) begin
        if (w_dem_hit && mem_write) begin
            for (int b = 0; b < int'(BE_W); b++) begin
                if (mem_byte_enable256[b])
                    r_data[w_idx][w_hit_way][8*b +: 8] <= mem_wdata256[8*b +: 8];
            end
        end
        if (w_pf_inst) begin
            r_data[w_idx][w_victim] <= pf_rdata;
            r_tag[w_idx][w_victim]  <= w_tag;
        end
        if (w_fill_done) begin
            r_data[w_idx][r_vway] <= pmem_rdata;
            r_tag[w_idx][r_vway]  <= w_tag;
        end
        if (w_pfwb_done) begin
            r_data[w_idx][r_vway] <= pf_rdata;
            r_tag[w_idx][r_vway]  <= w_tag;
        end
    end
endmodule

// File: tb/tb_prefetch_cache_nway.sv
// Scoreboard bench for prefetch_cache_nway: directed CPU/prefetch traffic, a pmem
// responder checking writeback/fill requests, and a monitor checking responses.
module tb_prefetch_cache_nway;
    localparam int unsigned LAT = 3;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [31:0]  mem_address = '0;
    logic         mem_read = 1'b0;
    logic         mem_write = 1'b0;
    logic [255:0] mem_wdata256 = '0;
    logic [31:0]  mem_byte_enable256 = '0;
    logic [255:0] mem_rdata256;
    logic         mem_resp;
    logic [31:0]  pmem_address;
    logic         pmem_read;
    logic         pmem_write;
    logic [255:0] pmem_wdata;
    logic [255:0] pmem_rdata = '0;
    logic         pmem_resp = 1'b0;
    logic         pf_valid = 1'b0;
    logic [31:0]  pf_address = '0;
    logic [255:0] pf_rdata = '0;
    logic         pf_ack;
    logic [31:0]  pf_useful_count;

    prefetch_cache_nway dut (
        .clk(clk), .rst(rst),
        .mem_address(mem_address), .mem_read(mem_read), .mem_write(mem_write),
        .mem_wdata256(mem_wdata256), .mem_byte_enable256(mem_byte_enable256),
        .mem_rdata256(mem_rdata256), .mem_resp(mem_resp),
        .pmem_address(pmem_address), .pmem_read(pmem_read), .pmem_write(pmem_write),
        .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
        .pf_valid(pf_valid), .pf_address(pf_address), .pf_rdata(pf_rdata),
        .pf_ack(pf_ack), .pf_useful_count(pf_useful_count)
    );

    always #5 clk = ~clk;

    typedef struct { bit is_pf; bit chk; logic [255:0] data; } resp_t;
    typedef struct { bit wr; logic [31:0] addr; logic [31:0] lo; } pm_t;

    resp_t resp_q[$];
    pm_t   pm_q[$];
    int    checks = 0;
    int    errors = 0;
    int    pm_cnt = 0;

    function automatic logic [255:0] line_of(input logic [31:0] a);
        logic [255:0] l;
        for (int i = 0; i < 8; i++) l[32*i +: 32] = a + 32'(i) * 32'h0101_0000;
        return l;
    endfunction

    function automatic logic [255:0] pf_line(input logic [31:0] a);
        return ~line_of(a);
    endfunction

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk256(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Response monitor: pops the scoreboard whenever the DUT completes something.
    always @(negedge clk) begin
        if (rst && (mem_resp || pf_ack)) begin
            chk32("resp_ack_exclusive", 32'(mem_resp & pf_ack), 32'd0);
            checks++;
            if (resp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_resp: got mem_resp=%0b pf_ack=%0b expected none", mem_resp, pf_ack);
            end else begin
                resp_t r;
                r = resp_q.pop_front();
                if (r.is_pf != pf_ack) begin
                    errors++;
                    $display("FAIL resp_order: got pf_ack=%0b expected pf_ack=%0b", pf_ack, r.is_pf);
                end else if (!r.is_pf && r.chk) begin
                    chk256("mem_rdata", mem_rdata256, r.data);
                end
            end
        end
    end

    // Pmem responder: answers after LAT cycles and checks each request it completes.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            pmem_resp = 1'b0;
            if (rst && (pmem_read || pmem_write)) begin
                pm_cnt++;
                if (pm_cnt == int'(LAT)) begin
                    pm_cnt     = 0;
                    pmem_rdata = line_of(pmem_address);
                    pmem_resp  = 1'b1;
                    checks++;
                    if (pm_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_pmem: got addr %h wr=%0b expected none", pmem_address, pmem_write);
                    end else begin
                        pm_t e;
                        e = pm_q.pop_front();
                        chk32("pmem_write", 32'(pmem_write), 32'(e.wr));
                        chk32("pmem_address", pmem_address, e.addr);
                        if (e.wr) chk32("pmem_wdata_lo", pmem_wdata[31:0], e.lo);
                    end
                end
            end else begin
                pm_cnt = 0;
            end
        end
    end

    task automatic exp_pm(input bit wr, input logic [31:0] a, input logic [31:0] lo);
        pm_t e;
        e.wr = wr; e.addr = a; e.lo = lo;
        pm_q.push_back(e);
    endtask

    task automatic exp_resp(input bit is_pf, input bit chk, input logic [255:0] d);
        resp_t r;
        r.is_pf = is_pf; r.chk = chk; r.data = d;
        resp_q.push_back(r);
    endtask

    task automatic cpu(input bit wr, input logic [31:0] a, input logic [31:0] wd,
                       input int exp_n);
        bit got;
        int n;
        @(posedge clk);
        #1;
        mem_address        = a;
        mem_read           = !wr;
        mem_write          = wr;
        mem_wdata256       = 256'(wd);
        mem_byte_enable256 = 32'h0000_000F;
        n = 0; got = 1'b0;
        while (!got && n < 100) begin
            @(negedge clk);
            n++;
            got = mem_resp;
        end
        chk32("cpu_latency", 32'(n), 32'(exp_n));
        @(posedge clk);
        #1;
        mem_read  = 1'b0;
        mem_write = 1'b0;
    endtask

    task automatic pf(input logic [31:0] a, input logic [255:0] d, input int exp_n);
        bit got;
        int n;
        @(posedge clk);
        #1;
        pf_valid = 1'b1; pf_address = a; pf_rdata = d;
        n = 0; got = 1'b0;
        while (!got && n < 100) begin
            @(negedge clk);
            n++;
            got = pf_ack;
        end
        chk32("pf_latency", 32'(n), 32'(exp_n));
        @(posedge clk);
        #1;
        pf_valid = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, input logic [255:0] d, input int exp_n);
        exp_resp(1'b0, 1'b1, d);
        cpu(1'b0, a, 32'h0, exp_n);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] wd, input int exp_n);
        exp_resp(1'b0, 1'b0, '0);
        cpu(1'b1, a, wd, exp_n);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200us");
        $fatal(1, "watchdog");
    end

    localparam int MISS = int'(LAT) + 2;
    localparam int MISS_WB = 2 * int'(LAT) + 2;

    initial begin
        logic [255:0] d;
        #2;
        chk32("rst_pmem_read", 32'(pmem_read), 32'd0);
        chk32("rst_pmem_write", 32'(pmem_write), 32'd0);
        chk32("rst_mem_resp", 32'(mem_resp), 32'd0);
        chk32("rst_pf_ack", 32'(pf_ack), 32'd0);
        chk32("rst_useful", pf_useful_count, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;

        // Cold miss then hit.
        exp_pm(1'b0, 32'h100, 32'h0);
        rd(32'h100, line_of(32'h100), MISS);
        rd(32'h100, line_of(32'h100), 1);

        // Fill set 0, touch 0x000, then 0x400 replaces an untouched clean way.
        exp_pm(1'b0, 32'h000, 32'h0); rd(32'h000, line_of(32'h000), MISS);
        exp_pm(1'b0, 32'h200, 32'h0); rd(32'h200, line_of(32'h200), MISS);
        exp_pm(1'b0, 32'h300, 32'h0); rd(32'h300, line_of(32'h300), MISS);
        rd(32'h000, line_of(32'h000), 1);
        exp_pm(1'b0, 32'h400, 32'h0); rd(32'h400, line_of(32'h400), MISS);
        rd(32'h000, line_of(32'h000), 1);

        // Dirty line 0x100 becomes LRU and is written back before the fill.
        wr(32'h100, 32'hDEAD_BEEF, 1);
        d = line_of(32'h100);
        d[31:0] = 32'hDEAD_BEEF;
        rd(32'h100, d, 1);
        rd(32'h000, line_of(32'h000), 1);
        rd(32'h300, line_of(32'h300), 1);
        exp_pm(1'b1, 32'h100, 32'hDEAD_BEEF);
        exp_pm(1'b0, 32'h500, 32'h0);
        rd(32'h500, line_of(32'h500), MISS_WB);

        // Prefetch into an empty set, then demand-hit it.
        exp_resp(1'b1, 1'b0, '0);
        pf(32'h520, pf_line(32'h520), 1);
        chk32("useful_after_pf", pf_useful_count, 32'd0);
        rd(32'h520, pf_line(32'h520), 1);
        chk32("useful_first_hit", pf_useful_count, 32'd1);
        rd(32'h520, pf_line(32'h520), 1);
        chk32("useful_second_hit", pf_useful_count, 32'd1);

        // Demand and prefetch together: demand first.
        exp_resp(1'b0, 1'b1, line_of(32'h500));
        exp_resp(1'b1, 1'b0, '0);
        fork
            cpu(1'b0, 32'h500, 32'h0, 1);
            pf(32'h540, pf_line(32'h540), 2);
        join
        rd(32'h540, pf_line(32'h540), 1);
        chk32("useful_concurrent", pf_useful_count, 32'd2);

        // Prefetch of a present line is dropped.
        exp_resp(1'b1, 1'b0, '0);
        pf(32'h000, pf_line(32'h000), 1);
        rd(32'h000, line_of(32'h000), 1);
        chk32("useful_dropped_pf", pf_useful_count, 32'd2);

        // Prefetch evicting a dirty line goes through PF_WB.
        wr(32'h400, 32'hCAFE_F00D, 1);
        rd(32'h300, line_of(32'h300), 1);
        rd(32'h500, line_of(32'h500), 1);
        exp_pm(1'b1, 32'h400, 32'hCAFE_F00D);
        exp_resp(1'b1, 1'b0, '0);
        pf(32'h600, pf_line(32'h600), int'(LAT) + 1);
        rd(32'h600, pf_line(32'h600), 1);
        chk32("useful_pfwb", pf_useful_count, 32'd3);

        // Reset in the middle of a fill.
        @(posedge clk);
        #1;
        mem_address = 32'h700;
        mem_read    = 1'b1;
        @(posedge clk);
        #2;
        chk32("abort_pmem_read_before", 32'(pmem_read), 32'd1);
        chk32("abort_pmem_addr", pmem_address, 32'h700);
        rst = 1'b0;
        #1;
        chk32("abort_pmem_read_after", 32'(pmem_read), 32'd0);
        chk32("abort_useful", pf_useful_count, 32'd0);
        mem_read = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;

        // Everything is invalid after reset.
        exp_pm(1'b0, 32'h520, 32'h0);
        rd(32'h520, line_of(32'h520), MISS);
        exp_pm(1'b0, 32'h000, 32'h0);
        rd(32'h000, line_of(32'h000), MISS);
        chk32("useful_after_refill", pf_useful_count, 32'd0);

        repeat (5) @(posedge clk);
        chk32("resp_queue_empty", 32'(resp_q.size()), 32'd0);
        chk32("pmem_queue_empty", 32'(pm_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/prefetch_cache_nway.md
Name: prefetch_cache_nway

Overview:
- Parametrised N-way set-associative L2-side cache with an integrated control FSM and a prefetch install port.
- Generalises the 2-way prefetch cache datapath: configurable way count and set count, tree-PLRU replacement, dirty writeback for both demand and prefetch victims, and per-line prefetch tracking with a useful-prefetch counter.
- Sits between the bus adapter (CPU side) and the cacheline adapter (pmem side). The stream prefetcher feeds it through the pf_* port.

Parameters:
- S_OFFSET, 5, byte-offset bits (line = 2**S_OFFSET bytes, 256 bits at default).
- S_INDEX, 3, index bits (sets = 2**S_INDEX).
- NUM_WAYS, 4, associativity; power of two, >=2.
- S_TAG, 32-S_OFFSET-S_INDEX, tag width (derived).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- mem_address  in  32  CPU line address
- mem_read  in  1  CPU read request
- mem_write  in  1  CPU write request
- mem_wdata256  in  256  CPU write data
- mem_byte_enable256  in  32  CPU byte enables
- mem_rdata256  out  256  read data of hit way
- mem_resp  out  1  request complete
- pmem_address  out  32  line-aligned pmem address
- pmem_read  out  1  pmem read
- pmem_write  out  1  pmem write
- pmem_wdata  out  256  victim line
- pmem_rdata  in  256  fill line
- pmem_resp  in  1  pmem done
- pf_valid  in  1  prefetch line offered
- pf_address  in  32  prefetch line address
- pf_rdata  in  256  prefetch line data
- pf_ack  out  1  prefetch consumed (installed or dropped)
- pf_useful_count  out  32  demand hits on not-yet-touched prefetched lines

Behaviour:
- Reset (rst=0, async): state IDLE; all valid/dirty/pf bits and PLRU bits clear; pf_useful_count=0; every output 0. Data and tag arrays are not reset. Reset mid-WB/FILL aborts: pmem_read and pmem_write drop immediately.
- Address split: tag=[31:S_OFFSET+S_INDEX], index=[S_OFFSET+S_INDEX-1:S_OFFSET]. pmem_address is always {tag, index, S_OFFSET'b0}.
- Lookup is combinational against all ways; hit = tag match and valid. At most one way hits.
- Victim selection: lowest-index invalid way; if none are invalid, the tree-PLRU victim.
- PLRU: NUM_WAYS-1 bits per set. A demand access to way w flips every node on w's path to point away from w.
- States: IDLE, WB, FILL, PF_WB.
- IDLE, demand request (mem_read|mem_write):
  - Hit: mem_resp=1 in the same cycle.
  - Read: mem_rdata256 = hit way data.
  - Write: at the clock edge, bytes per mem_byte_enable256 are written and dirty is set.
  - PLRU updated.
  - If the line's pf bit is set, clear it and increment pf_useful_count (wraps at 2**32).
  - Miss, victim valid&dirty: go to WB. Otherwise go to FILL.
- WB: pmem_write=1, pmem_address = victim tag/index, pmem_wdata = victim data. On pmem_resp, go to FILL.
- FILL: pmem_read=1, pmem_address = request address. On pmem_resp:
  - Write the full line into the victim; tag loaded; valid=1, dirty=0, pf=0.
  - Return to IDLE. The request re-looks-up and hits next cycle, so miss latency = pmem latency(s) + 1.
- IDLE, no demand, pf_valid=1: lookup on pf_address.
  - Already present: pf_ack=1 and drop.
  - Victim clean or invalid: install in 1 cycle (data=pf_rdata, valid=1, dirty=0, pf=1), pf_ack=1.
  - Victim dirty: go to PF_WB.
  - Prefetch installs do not update PLRU. The line stays at the LRU position until demand-touched.
- PF_WB: writes back the victim exactly as WB does. On pmem_resp, install the prefetch line, pf_ack=1, return to IDLE.
- Priority: a demand request beats prefetch in IDLE. The prefetcher holds pf_valid/pf_address/pf_rdata stable until pf_ack. The CPU holds its request stable until mem_resp.
- A demand request arriving during PF_WB waits. mem_resp is never asserted outside IDLE.
- mem_resp and pf_ack are 1-cycle pulses and are never asserted together.

Test Plan:
- Reset, then read 0x0000_0100: FILL with pmem_address=0x0000_0100. After pmem_resp, mem_resp asserts next cycle with the pmem data. A second read hits in 1 cycle with no pmem activity.
- Fill 4 lines in set 0 (0x000, 0x100, 0x200, 0x300), touch 0x000, then read 0x400: the victim is not way 0 and pmem_read=1 for 0x400, with no writeback.
- Write 0xDEADBEEF, byte_enable=0x0000000F, to 0x100 hit; evict it by filling the set. Required: pmem_write=1, pmem_address=0x100, low word of pmem_wdata=0xDEADBEEF, then FILL.
- pf_valid with pf_address=0x0000_0520 on an idle empty cache: pf_ack in 1 cycle. Demand read 0x520 hits immediately and pf_useful_count becomes 1. A second read keeps it at 1.
- Assert mem_read and pf_valid together: the demand is serviced first, pf_ack comes only after mem_resp. A prefetch of a line already present is acked with no array change.
- Dirty victim on prefetch: PF_WB writes back, then installs; pf_ack follows pmem_resp. Deassert rst mid-FILL: pmem_read=0 immediately and all lines are invalid.
